// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, runs the SRAM request/response handshake,
// applies execute-stage redirects and presents one {pc, inst} pair to decode at a time.
// Optional misaligned-redirect trapping (if_adel, ERR state) is enabled by FETCH_ADDR_CHECK_EN.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  output logic        ce,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst
`ifdef FETCH_ADDR_CHECK_EN
  ,
  output logic        if_adel
`endif
);

  typedef enum logic [2:0] {
    S_BOOT,
    S_REQ,
    S_WAIT,
    S_OUT
`ifdef FETCH_ADDR_CHECK_EN
    ,
    S_ERR
`endif
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        kill_q, kill_d;
  logic        ce_q, ce_d;
  logic        inst_req_q, inst_req_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_inst_q, if_inst_d;
`ifdef FETCH_ADDR_CHECK_EN
  logic        if_adel_q, if_adel_d;
`endif

  logic        go_fetch;
  logic [31:0] fetch_pc;
  logic [31:0] tgt;

  // With address checking the target is kept verbatim so a misaligned one can be reported.
  function automatic logic [31:0] redirect_pc(input logic [31:0] t);
`ifdef FETCH_ADDR_CHECK_EN
    return t;
`else
    return {t[31:2], 2'b00};
`endif
  endfunction

`ifndef FETCH_ADDR_CHECK_EN
  logic unused_tgt_bits;
  assign unused_tgt_bits = ^redirect_target[1:0];
`endif

  assign tgt = redirect_pc(redirect_target);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    kill_d     = kill_q;
    ce_d       = ce_q;
    if_valid_d = if_valid_q;
    if_pc_d    = if_pc_q;
    if_inst_d  = if_inst_q;
`ifdef FETCH_ADDR_CHECK_EN
    if_adel_d  = if_adel_q;
`endif
    go_fetch   = 1'b0;
    fetch_pc   = pc_q;

    case (state_q)
      S_BOOT: begin
        ce_d    = 1'b1;
        state_d = S_REQ;
      end
      S_REQ: begin
        if (inst_addr_ok) begin
          // An accepted request is in flight even if redirected; its data must be dropped.
          state_d = S_WAIT;
          if (redirect_valid) begin
            kill_d = 1'b1;
            pc_d   = tgt;
          end
        end else if (redirect_valid) begin
          go_fetch = 1'b1;
          fetch_pc = tgt;
        end
      end
      S_WAIT: begin
        if (inst_data_ok) begin
          if (kill_q || redirect_valid) begin
            kill_d   = 1'b0;
            go_fetch = 1'b1;
            fetch_pc = redirect_valid ? tgt : pc_q;
          end else begin
            if_inst_d  = inst_rdata;
            if_pc_d    = pc_q;
            if_valid_d = 1'b1;
            pc_d       = pc_q + 32'd4;
            state_d    = S_OUT;
          end
        end else if (redirect_valid) begin
          kill_d = 1'b1;
          pc_d   = tgt;
        end
      end
      S_OUT: begin
        if (redirect_valid) begin
          if_valid_d = 1'b0;
`ifdef FETCH_ADDR_CHECK_EN
          if_adel_d  = 1'b0;
`endif
          go_fetch   = 1'b1;
          fetch_pc   = tgt;
        end else if (!stall) begin
          if_valid_d = 1'b0;
`ifdef FETCH_ADDR_CHECK_EN
          if_adel_d  = 1'b0;
          state_d    = if_adel_q ? S_ERR : S_REQ;
`else
          state_d    = S_REQ;
`endif
        end
      end
`ifdef FETCH_ADDR_CHECK_EN
      S_ERR: begin
        if (redirect_valid) begin
          go_fetch = 1'b1;
          fetch_pc = tgt;
        end
      end
`endif
      default: state_d = S_BOOT;
    endcase

    // Common entry into a new fetch; a misaligned address is presented as a fault instead.
    if (go_fetch) begin
      pc_d    = fetch_pc;
      state_d = S_REQ;
`ifdef FETCH_ADDR_CHECK_EN
      if (|fetch_pc[1:0]) begin
        state_d    = S_OUT;
        if_valid_d = 1'b1;
        if_adel_d  = 1'b1;
        if_pc_d    = fetch_pc;
        if_inst_d  = 32'h0;
      end
`endif
    end

    inst_req_d = (state_d == S_REQ);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_BOOT;
      pc_q       <= RESET_PC;
      kill_q     <= 1'b0;
      ce_q       <= 1'b0;
      inst_req_q <= 1'b0;
      if_valid_q <= 1'b0;
      if_pc_q    <= 32'h0;
      if_inst_q  <= 32'h0;
`ifdef FETCH_ADDR_CHECK_EN
      if_adel_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      kill_q     <= kill_d;
      ce_q       <= ce_d;
      inst_req_q <= inst_req_d;
      if_valid_q <= if_valid_d;
      if_pc_q    <= if_pc_d;
      if_inst_q  <= if_inst_d;
`ifdef FETCH_ADDR_CHECK_EN
      if_adel_q  <= if_adel_d;
`endif
    end
  end

  assign inst_req  = inst_req_q;
  assign inst_addr = pc_q;
  assign ce        = ce_q;
  assign if_valid  = if_valid_q;
  assign if_pc     = if_pc_q;
  assign if_inst   = if_inst_q;
`ifdef FETCH_ADDR_CHECK_EN
  assign if_adel   = if_adel_q;
`endif

endmodule
